// File: rtl/sccb_cfg_ctrl.sv
// SCCB configuration controller: after power-up, walks a {sub_addr, data} ROM table and
// writes every entry to the sensor as a 3-phase SCCB write, then raises cfg_done.
module sccb_cfg_ctrl #(
    parameter int          CLK_FREQ  = 50000000,
    parameter int          SCCB_FREQ = 100000,
    parameter logic [7:0]  DEV_ID    = 8'h42,
    parameter logic [7:0]  REG_NUM   = 8'd165,
    parameter logic [31:0] PWR_WAIT  = 32'd1000000,
    parameter logic [31:0] RST_WAIT  = 32'd50000,
    parameter int          GAP_Q     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  tbl_idx,
    input  logic [15:0] tbl_data,
    output logic        sccb_scl,
    output logic        sccb_sda_o,
    output logic        sccb_sda_oe,
    output logic        busy,
    output logic        cfg_done
);
    localparam int          QDIV     = CLK_FREQ / (4 * SCCB_FREQ);
    localparam logic [31:0] QDIV_M1  = 32'(QDIV - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_Q - 1);

    localparam logic [2:0] S_PWR   = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_BITS  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  qtr_q, qtr_d;
    logic [4:0]  slot_q, slot_d;
    logic [7:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        xtra_q, xtra_d;
    logic [23:0] sh_q, sh_d;
    logic        swrst_q, swrst_d;
    logic        scl_q, sda_q, oe_q, busy_q;
    logic        tick, gap_end;

    // Slots 8, 17 and 26 are the ACK positions; the bus is released there.
    function automatic logic is_dc(input logic [4:0] slot);
        return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
    endfunction

    // Bus levels {scl, sda, oe} for a given state / quarter / slot.
    function automatic logic [2:0] bus_drive(input logic [2:0] st, input logic [7:0] qtr,
                                             input logic [4:0] slot, input logic msb);
        logic [2:0] v;
        v = 3'b111;
        case (st)
            S_START: v = (qtr == 8'd0) ? 3'b101 : 3'b001;
            S_BITS: begin
                v[2] = (qtr[1:0] == 2'd1) || (qtr[1:0] == 2'd2);
                v[1] = is_dc(slot) ? 1'b1 : msb;
                v[0] = ~is_dc(slot);
            end
            S_STOP:  v = (qtr == 8'd0) ? 3'b001 : ((qtr == 8'd1) ? 3'b101 : 3'b111);
            default: v = 3'b111;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        qtr_d   = qtr_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        done_d  = done_q;
        xtra_d  = xtra_q;
        sh_d    = sh_q;
        swrst_d = swrst_q;
        gap_end = 1'b0;
        tick    = (cnt_q == QDIV_M1);
        case (state_q)
            S_PWR: begin
                if (cnt_q + 32'd1 >= PWR_WAIT) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                // Second FETCH cycle: the synchronous ROM output now matches tbl_idx.
                if (cnt_q == 32'd1) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    qtr_d   = '0;
                    sh_d    = {DEV_ID, tbl_data};
                    swrst_d = (tbl_data == 16'h1280);
                end
            end
            S_START: begin
                if (tick) begin
                    cnt_d = '0;
                    if (qtr_q == 8'd1) begin
                        state_d = S_BITS;
                        qtr_d   = '0;
                        slot_d  = '0;
                    end else begin
                        qtr_d = qtr_q + 8'd1;
                    end
                end
            end
            S_BITS: begin
                if (tick) begin
                    cnt_d = '0;
                    if (qtr_q == 8'd3) begin
                        qtr_d = '0;
                        if (!is_dc(slot_q)) sh_d = {sh_q[22:0], 1'b0};
                        if (slot_q == 5'd26) state_d = S_STOP;
                        else                 slot_d  = slot_q + 5'd1;
                    end else begin
                        qtr_d = qtr_q + 8'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (qtr_q == 8'd2) begin
                        state_d = S_GAP;
                        qtr_d   = '0;
                        xtra_d  = 1'b0;
                    end else begin
                        qtr_d = qtr_q + 8'd1;
                    end
                end
            end
            S_GAP: begin
                // A sensor soft reset needs extra settling time before the next write.
                if (xtra_q) begin
                    if (cnt_q + 32'd1 >= RST_WAIT) gap_end = 1'b1;
                end else if (tick) begin
                    cnt_d = '0;
                    if (qtr_q == GAP_LAST) begin
                        if (swrst_q && (RST_WAIT != 32'd0)) xtra_d  = 1'b1;
                        else                                gap_end = 1'b1;
                    end else begin
                        qtr_d = qtr_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_PWR;
        endcase
        if (gap_end) begin
            cnt_d  = '0;
            xtra_d = 1'b0;
            if (idx_q == REG_NUM - 8'd1) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + 8'd1;
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PWR;
            cnt_q   <= '0;
            qtr_q   <= '0;
            slot_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            xtra_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            xtra_q  <= xtra_d;
            {scl_q, sda_q, oe_q} <= bus_drive(state_d, qtr_d, slot_d, sh_d[23]);
            busy_q  <= (state_d != S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        sh_q    <= sh_d;
        swrst_q <= swrst_d;
    end

    assign tbl_idx     = idx_q;
    assign sccb_scl    = scl_q;
    assign sccb_sda_o  = sda_q;
    assign sccb_sda_oe = oe_q;
    assign busy        = busy_q;
    assign cfg_done    = done_q;
endmodule

// File: tb/tb_sccb_cfg_ctrl.sv
// Bench for sccb_cfg_ctrl: a pin-level SCCB bus monitor decodes each write and checks it
// against a scoreboard of table entries pushed whenever a configuration run is launched.
module tb_sccb_cfg_ctrl;
    localparam int          CLK_FREQ = 800;
    localparam int          SCCB_FRQ = 100;
    localparam int          QDIV     = 2;
    localparam int          GAP_Q    = 8;
    localparam int          NREG     = 4;
    localparam logic [7:0]  DEV      = 8'h42;
    localparam logic [31:0] PWR      = 32'd10;
    localparam logic [31:0] RSTW     = 32'd100;
    localparam logic [26:0] EXP_OE   = ~((27'd1 << 8) | (27'd1 << 17) | (27'd1 << 26));

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] ent;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [7:0]  tbl_idx, idx1;
    logic [15:0] tbl_data, data1;
    logic        scl, sda_o, sda_oe, busy, cfg_done;
    logic        scl1, sda1, oe1, busy1, done1;
    logic [15:0] rom [NREG];

    int   errors = 0, checks = 0, cyc = 0;
    exp_t sb_q[$];

    sccb_cfg_ctrl #(.CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FRQ), .DEV_ID(DEV), .REG_NUM(8'(NREG)),
                    .PWR_WAIT(PWR), .RST_WAIT(RSTW), .GAP_Q(GAP_Q)) dut (
        .clk(clk), .rst(rst), .start(start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
        .sccb_scl(scl), .sccb_sda_o(sda_o), .sccb_sda_oe(sda_oe), .busy(busy), .cfg_done(cfg_done));

    sccb_cfg_ctrl #(.CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FRQ), .DEV_ID(DEV), .REG_NUM(8'd1),
                    .PWR_WAIT(PWR), .RST_WAIT(RSTW), .GAP_Q(GAP_Q)) dut1 (
        .clk(clk), .rst(rst), .start(1'b0), .tbl_idx(idx1), .tbl_data(data1),
        .sccb_scl(scl1), .sccb_sda_o(sda1), .sccb_sda_oe(oe1), .busy(busy1), .cfg_done(done1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tbl_data <= (int'(tbl_idx) < NREG) ? rom[tbl_idx[1:0]] : 16'h0000;
    always @(posedge clk) data1 <= 16'h1204;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Bus monitor state
    logic        prev_scl = 1'b1, prev_sda = 1'b1, prev_done = 1'b0;
    logic        in_txn = 1'b0, gap_valid = 1'b0, anchor_valid = 1'b0, idx_over = 1'b0;
    int          nrise = 0, start_cyc = 0, stop_cyc = 0, exp_gap = 0, exp_done = 0;
    int          anchor_cyc = 0, anchor_lat = 0;
    logic [7:0]  txn_idx = 8'h0;
    logic [26:0] bits_v = '0, oes_v = '0;

    always @(negedge clk) begin : mon
        logic       bus;
        logic [7:0] dev, sub, dat;
        exp_t       e;
        bus = sda_oe ? sda_o : 1'b1;
        if (rst) begin
            in_txn    = 1'b0;
            gap_valid = 1'b0;
            nrise     = 0;
        end else begin
            if (int'(tbl_idx) >= NREG) idx_over = 1'b1;
            if (prev_scl && scl && prev_sda && !bus) begin
                if (anchor_valid) begin
                    check("first_start_lat", cyc - anchor_cyc, anchor_lat);
                    anchor_valid = 1'b0;
                end else if (gap_valid) begin
                    check("gap_len", cyc - stop_cyc, exp_gap);
                end
                gap_valid = 1'b0;
                in_txn    = 1'b1;
                nrise     = 0;
                start_cyc = cyc;
                txn_idx   = tbl_idx;
            end else if (in_txn && !prev_scl && scl) begin
                if (nrise < 27) begin
                    bits_v[nrise] = bus;
                    oes_v[nrise]  = sda_oe;
                end
                nrise++;
            end else if (in_txn && prev_scl && scl && !prev_sda && bus) begin
                in_txn   = 1'b0;
                stop_cyc = cyc;
                check("scl_rises", nrise, 28);
                check("txn_len", cyc - start_cyc, 112 * QDIV);
                check("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    for (int k = 0; k < 8; k++) begin
                        dev[7-k] = bits_v[k];
                        sub[7-k] = bits_v[9+k];
                        dat[7-k] = bits_v[18+k];
                    end
                    check("dev_id", dev, DEV);
                    check("entry", {sub, dat}, e.ent);
                    check("txn_tbl_idx", txn_idx, e.idx);
                    check("sda_oe_slots", oes_v, EXP_OE);
                    exp_done  = QDIV * (1 + GAP_Q) + ((e.ent == 16'h1280) ? int'(RSTW) : 0);
                    exp_gap   = exp_done + 2;
                    gap_valid = 1'b1;
                end
            end
            if (!prev_done && cfg_done) begin
                check("done_lat", cyc - stop_cyc, exp_done);
                check("sb_drained", sb_q.size(), 0);
                gap_valid = 1'b0;
            end
        end
        prev_scl  = scl;
        prev_sda  = bus;
        prev_done = cfg_done;
    end

    // Single-entry instance: count SCL rises and time its first cfg_done
    logic p_scl1 = 1'b1;
    int   n1 = 0, d1_cyc = -1, rel_cyc = 0;
    always @(negedge clk) begin : mon1
        if (rst) begin
            n1     = 0;
            p_scl1 = 1'b1;
        end else begin
            if (!p_scl1 && scl1) n1++;
            if (done1 && d1_cyc < 0) d1_cyc = cyc;
            p_scl1 = scl1;
        end
    end

    task automatic push_table();
        for (int i = 0; i < NREG; i++) sb_q.push_back('{idx: 8'(i), ent: rom[i]});
    endtask

    task automatic randomize_table();
        for (int i = 0; i < NREG; i++) rom[i] = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!cfg_done && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check(name, cfg_done, 1'b1);
        check({name, "_busy"}, busy, 1'b0);
    endtask

    task automatic wait_slot(input int n);
        int k;
        k = 0;
        while (!(in_txn && nrise == n) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("reach_slot", in_txn && nrise == n, 1'b1);
    endtask

    task automatic pulse_start();
        anchor_cyc   = cyc;
        anchor_lat   = 3;
        anchor_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        rom[0] = 16'h1204;
        rom[1] = 16'h1280;
        rom[2] = 16'($urandom_range(0, 65535));
        rom[3] = 16'h40D0;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda_o, 1'b1);
        check("rst_oe", sda_oe, 1'b1);
        check("rst_busy", busy, 1'b1);
        check("rst_done", cfg_done, 1'b0);
        check("rst_idx", tbl_idx, 8'd0);

        // Run 1: power-up configuration
        push_table();
        anchor_cyc   = cyc;
        anchor_lat   = int'(PWR) + 2;
        anchor_valid = 1'b1;
        rel_cyc      = cyc;
        rst          = 1'b0;
        wait_done("run1_done");
        check("one_entry_done_lat", d1_cyc - rel_cyc, int'(PWR) + 2 + 113 * QDIV + GAP_Q * QDIV);
        check("one_entry_rises", n1, 28);
        check("one_entry_idx", idx1, 8'd0);
        repeat (5) @(negedge clk);

        // Run 2: restart from DONE, with a start pulse mid-transaction that must be ignored
        randomize_table();
        push_table();
        pulse_start();
        check("restart_done_low", cfg_done, 1'b0);
        check("restart_busy", busy, 1'b1);
        check("restart_idx", tbl_idx, 8'd0);
        wait_slot(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_busy", busy, 1'b1);
        wait_done("run2_done");
        repeat (3) @(negedge clk);

        // Run 3: reset in the middle of slot 12, then full restart from power-up
        randomize_table();
        push_table();
        pulse_start();
        wait_slot(13);
        #2 rst = 1'b1;
        #1;
        check("abort_scl", scl, 1'b1);
        check("abort_sda", sda_o, 1'b1);
        check("abort_oe", sda_oe, 1'b1);
        check("abort_done", cfg_done, 1'b0);
        check("abort_busy", busy, 1'b1);
        check("abort_idx", tbl_idx, 8'd0);
        sb_q.delete();
        anchor_valid = 1'b0;
        repeat (4) @(negedge clk);
        push_table();
        anchor_cyc   = cyc;
        anchor_lat   = int'(PWR) + 2;
        anchor_valid = 1'b1;
        rst          = 1'b0;
        wait_done("run3_done");
        check("idx_in_range", idx_over, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sccb_cfg_ctrl.md
Name: sccb_cfg_ctrl

Overview:
- Configures the camera sensor over SCCB (3-phase write only) from an external register table after power-up.
- Asserts cfg_done once the whole table is written. cfg_done gates the pixel receiver.
- Runs in the system clock domain. cfg_done is resynchronised into the pixel-clock domain by the receiver.
- Walks a ROM table of {sub_addr, data} entries and sequences the bit-level SCL/SDA waveform itself.

Parameters:
- CLK_FREQ, 50000000: clk frequency in Hz.
- SCCB_FREQ, 100000: SCL frequency in Hz. Quarter-period QDIV = CLK_FREQ/(4*SCCB_FREQ) clk cycles; QDIV must be >= 1.
- DEV_ID, 8'h42: SCCB write device ID, sent as the first phase of every write.
- REG_NUM, 8'd165: number of table entries, indices 0..REG_NUM-1.
- PWR_WAIT, 32'd1000000: clk cycles idle after reset before the first transaction.
- RST_WAIT, 32'd50000: extra clk cycles waited after writing the soft-reset entry 16'h1280.
- GAP_Q, 8: idle quarter-periods between consecutive transactions.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle pulse that re-runs the full configuration. Honoured only in DONE.
- tbl_idx, output, 8: table read index.
- tbl_data, input, 16: {sub_addr[15:8], data[7:0]}. Valid one clk after tbl_idx changes (synchronous ROM).
- sccb_scl, output, 1: SCCB clock.
- sccb_sda_o, output, 1: SDA drive value.
- sccb_sda_oe, output, 1: 1 = drive SDA; 0 = release (don't-care bit).
- busy, input-independent output, 1: high in every state except DONE.
- cfg_done, output, 1: configuration complete; held high until rst or start.

Behaviour:
Reset values: tbl_idx=0, sccb_scl=1, sccb_sda_o=1, sccb_sda_oe=1, busy=1, cfg_done=0, state=PWR.

Timing:
- A quarter-tick is one pulse every QDIV clk cycles. The divider restarts on each state entry.
- All SCL/SDA changes happen on quarter-ticks.

States:
- PWR: count PWR_WAIT cycles, then go to FETCH.
- FETCH: 2 clk cycles (ROM latency). Latch tbl_data into a shift register as {DEV_ID, sub_addr, data} (24 bits). Go to START.
- START: 2 quarters.
  - q0: SDA=0 with SCL=1.
  - q1: SCL=0.
- BITS: 27 bit-slots, 4 quarters each. Order is 8 bits DEV_ID (MSB first), 1 don't-care, 8 sub_addr, 1 don't-care, 8 data, 1 don't-care.
  - q0: SCL=0, SDA=next bit.
  - q1, q2: SCL=1.
  - q3: SCL=0.
  - Don't-care slots (slots 8, 17, 26): sda_oe=0, sda_o=1. ACK is not sampled or checked.
- STOP: 3 quarters.
  - q0: SCL=0, SDA=0, oe=1.
  - q1: SCL=1.
  - q2: SDA=1.
- GAP: GAP_Q quarters with SCL=1, SDA=1.
  - If the latched entry was 16'h1280, add RST_WAIT clk cycles.
  - Then: if tbl_idx==REG_NUM-1, go to DONE; otherwise tbl_idx+1 and go to FETCH.
- DONE: cfg_done=1, busy=0, bus idle (SCL=1, SDA=1, oe=1).
  - start pulse: next cycle cfg_done=0, busy=1, tbl_idx=0, state=FETCH. PWR is not repeated.

Transaction length: 113 quarters = 113*QDIV clk cycles from START entry to STOP end.

Boundary conditions:
- start outside DONE is ignored.
- REG_NUM=1: exactly one transaction, then DONE.
- tbl_idx never exceeds REG_NUM-1.
- rst mid-transaction: outputs go to reset values immediately; the sequence restarts from PWR (no partial stop is generated).
- Counters are wide enough that PWR_WAIT and RST_WAIT do not wrap.

Test Plan:
1. Reset release, QDIV=2 (CLK_FREQ=800, SCCB_FREQ=100), PWR_WAIT=10 → first SDA fall with SCL=1 at cycle 12 after rst deassert (10 PWR + 2 FETCH). tbl_idx=0 throughout.
2. Table {0x1204, 0x40D0}, REG_NUM=2, DEV_ID=0x42 → bus model decodes writes 42/12/04 then 42/40/D0. sda_oe=0 during slots 8, 17, 26. Each transaction is 226 cycles. cfg_done rises after the second GAP.
3. Entry 0x1280 with RST_WAIT=100, GAP_Q=8 → gap before the next START is 16+100 cycles, versus 16 for other entries.
4. In DONE, pulse start → cfg_done low next cycle, tbl_idx=0, full table rewritten without PWR wait. A start pulse during BITS has no effect.
5. Assert rst at slot 12 of a transaction → same cycle sccb_scl=1, sda_o=1, cfg_done=0. Restart waits PWR_WAIT and begins again from index 0.
